// File: rtl/comp_mult_apb_regs.sv
// APB3 completer register file for the complex multiplier: operand/result pointers,
// operation count, start/sw-reset controls and done/status reporting. Optional IRQ: COMP_MULT_IRQ_EN.
module comp_mult_apb_regs #(
    parameter int APB_BADDR = 1024,
    parameter int SYS_AW    = 16,
    parameter int REG_DW    = 16,
    parameter int STS_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SYS_AW-1:0] apb_paddr,
    input  logic              apb_psel,
    input  logic              apb_penable,
    input  logic              apb_pwrite,
    input  logic [REG_DW-1:0] apb_pwdata,
    output logic              apb_pready,
    output logic [REG_DW-1:0] apb_prdata,
    output logic              apb_pslverr,
    output logic [SYS_AW-1:0] op1_addr,
    output logic [SYS_AW-1:0] op2_addr,
    output logic [SYS_AW-1:0] res_addr,
    output logic [REG_DW-1:0] nr_op,
    output logic              start,
    output logic              sw_rst,
    input  logic              core_busy,
    input  logic              core_done,
    input  logic [STS_W-1:0]  core_state
`ifdef COMP_MULT_IRQ_EN
    ,
    output logic              irq
`endif
);

`ifdef COMP_MULT_IRQ_EN
    localparam int NUM_REGS = 8;
`else
    localparam int NUM_REGS = 7;
`endif

    localparam logic [SYS_AW-1:0] BADDR = SYS_AW'(APB_BADDR);
    localparam logic [SYS_AW-1:0] NREGS = SYS_AW'(NUM_REGS);

    localparam logic [2:0] OFS_OP1    = 3'd0;
    localparam logic [2:0] OFS_OP2    = 3'd1;
    localparam logic [2:0] OFS_RES    = 3'd2;
    localparam logic [2:0] OFS_NR_OP  = 3'd3;
    localparam logic [2:0] OFS_CFG    = 3'd4;
    localparam logic [2:0] OFS_STOP   = 3'd5;
    localparam logic [2:0] OFS_STATUS = 3'd6;
    localparam logic [2:0] OFS_IRQ_EN = 3'd7;

    logic              r_pready;
    logic [REG_DW-1:0] r_prdata;
    logic              r_pslverr;
    logic [REG_DW-1:0] r_op1;
    logic [REG_DW-1:0] r_op2;
    logic [REG_DW-1:0] r_res;
    logic [REG_DW-1:0] r_nr_op;
    logic              r_sw_rst;
    logic              r_start;
    logic              r_stop;
    logic              r_nop_done;

    logic [SYS_AW-1:0] w_offset;
    logic [2:0]        w_idx;
    logic              w_valid_addr;
    logic              w_access;
    logic              w_err;
    logic              w_commit;
    logic              w_cfg_wr;
    logic              w_go;
    logic              w_stop_clr;
    logic              w_stop_next;
    logic [REG_DW-1:0] w_rdata;

`ifdef COMP_MULT_IRQ_EN
    logic r_irq_en;
    logic r_irq;
`endif

    assign w_offset     = apb_paddr - BADDR;
    assign w_idx        = w_offset[2:0];
    assign w_valid_addr = (apb_paddr >= BADDR) && (w_offset < NREGS);

    // The access cycle is taken only once; the following pready cycle completes it.
    assign w_access = apb_psel & apb_penable & ~r_pready;

    always_comb begin
        w_err = 1'b0;
        if (!w_valid_addr) begin
            w_err = 1'b1;
        end else if (apb_pwrite) begin
            case (w_idx)
                OFS_OP1, OFS_OP2, OFS_RES, OFS_NR_OP: w_err = core_busy;
                OFS_CFG:                              w_err = core_busy & apb_pwdata[0];
                OFS_STATUS:                           w_err = 1'b1;
                default:                              w_err = 1'b0;
            endcase
        end
    end

    assign w_commit = w_access & apb_pwrite & ~w_err;
    assign w_cfg_wr = w_commit && (w_idx == OFS_CFG);
    assign w_go     = w_cfg_wr & apb_pwdata[0] & ~apb_pwdata[1];

    assign w_stop_clr = (w_commit && (w_idx == OFS_STOP) && !apb_pwdata[0])
                      || w_go || (w_cfg_wr & apb_pwdata[1]);

    // sw reset dominates, then a completion event, then any clearing write.
    always_comb begin
        w_stop_next = r_stop;
        if (r_sw_rst)
            w_stop_next = 1'b0;
        else if (core_done || r_nop_done)
            w_stop_next = 1'b1;
        else if (w_stop_clr)
            w_stop_next = 1'b0;
    end

    always_comb begin
        w_rdata = '0;
        if (!w_err) begin
            case (w_idx)
                OFS_OP1:    w_rdata = r_op1;
                OFS_OP2:    w_rdata = r_op2;
                OFS_RES:    w_rdata = r_res;
                OFS_NR_OP:  w_rdata = r_nr_op;
                OFS_CFG:    w_rdata = REG_DW'({r_sw_rst, 1'b0});
                OFS_STOP:   w_rdata = REG_DW'(r_stop);
                OFS_STATUS: w_rdata = REG_DW'({core_state, core_busy});
`ifdef COMP_MULT_IRQ_EN
                OFS_IRQ_EN: w_rdata = REG_DW'(r_irq_en);
`endif
                default:    w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pready   <= 1'b0;
            r_prdata   <= '0;
            r_pslverr  <= 1'b0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_res      <= '0;
            r_nr_op    <= '0;
            r_sw_rst   <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_nop_done <= 1'b0;
        end else begin
            r_pready   <= w_access;
            r_pslverr  <= w_access & w_err;
            r_start    <= w_go && (r_nr_op != '0);
            r_nop_done <= w_go && (r_nr_op == '0);
            r_stop     <= w_stop_next;
            if (w_access && !apb_pwrite)
                r_prdata <= w_rdata;
            if (w_commit) begin
                case (w_idx)
                    OFS_OP1:   r_op1    <= apb_pwdata;
                    OFS_OP2:   r_op2    <= apb_pwdata;
                    OFS_RES:   r_res    <= apb_pwdata;
                    OFS_NR_OP: r_nr_op  <= apb_pwdata;
                    OFS_CFG:   r_sw_rst <= apb_pwdata[1];
                    default:   ;
                endcase
            end
        end
    end

`ifdef COMP_MULT_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq <= r_stop & r_irq_en;
            if (w_commit && (w_idx == OFS_IRQ_EN))
                r_irq_en <= apb_pwdata[0];
        end
    end

    assign irq = r_irq;
`endif

    assign apb_pready  = r_pready;
    assign apb_prdata  = r_prdata;
    assign apb_pslverr = r_pslverr;
    assign op1_addr    = SYS_AW'(r_op1);
    assign op2_addr    = SYS_AW'(r_op2);
    assign res_addr    = SYS_AW'(r_res);
    assign nr_op       = r_nr_op;
    assign start       = r_start;
    assign sw_rst      = r_sw_rst;

endmodule
